// File: rtl/avalon_burst_reader_if.sv
// Bus bundle for avalon_burst_reader.
//   master modport : the reader side. Drives the Avalon read request and the output stream.
//   slave modport  : the memory/sink side. Drives the slave responses and out_ready.
// Signals:
//   m_address, m_read                          read request (master -> slave)
//   m_waitrequest, m_readdata, m_readdatavalid slave response (slave -> master)
//   out_data, out_valid                        output stream (master -> sink)
//   out_ready                                  output stream backpressure (sink -> master)
interface avalon_burst_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output m_address, m_read, out_data, out_valid,
    input  m_waitrequest, m_readdata, m_readdatavalid, out_ready
  );

  modport slave (
    input  m_address, m_read, out_data, out_valid,
    output m_waitrequest, m_readdata, m_readdatavalid, out_ready
  );
endinterface

// File: rtl/avalon_burst_reader.sv
// Avalon-MM pipelined burst reader. It fetches word_count consecutive 32-bit words starting
// at base_addr and streams them out in address order through a small FIFO. The FIFO slots
// are handed out as credits, so reads in flight plus words buffered never exceed FIFO_DEPTH.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               begin a transfer; only sampled in IDLE
//   base_addr           byte address of the first word; bits [1:0] are ignored
//   word_count          number of words to read (0 gives an immediate done)
//   busy                high while a transfer is in progress
//   done                one-cycle pulse after the last word has been delivered
//   bus (master)        Avalon read request/response and the out_* stream
module avalon_burst_reader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [15:0]            word_count,
  output logic                   busy,
  output logic                   done,
  avalon_burst_reader_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, issued_q, delivered_q;
  logic [ADDR_W-1:0] addr_q;
  logic              m_read_q, m_read_d, busy_d, done_d;
  logic [CNT_W-1:0]  pending_q, fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              accept, push, pop, start_ok, last_issue, last_pop;
  logic [CRD_W-1:0]  credits_d;

  assign accept     = m_read_q && !bus.m_waitrequest;
  // A response with nothing in flight (e.g. from before a reset) is dropped.
  assign push       = bus.m_readdatavalid && (pending_q != '0);
  assign pop        = (fifo_cnt_q != '0) && bus.out_ready;
  assign start_ok   = (state_q == IDLE) && start;
  assign last_issue = accept && (issued_q == count_q - 16'd1);
  assign last_pop   = pop && (delivered_q == count_q - 16'd1);

  // Credits after this cycle; this cycle's pop frees its slot immediately.
  assign credits_d  = CRD_W'(pending_q) + CRD_W'(fifo_cnt_q) + CRD_W'(accept) - CRD_W'(pop);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && (word_count != 16'd0)) state_d = ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs. A stalled request stays asserted because
  // credits cannot grow while it waits.
  always_comb begin
    m_read_d = 1'b0;
    busy_d   = (state_d != IDLE);
    done_d   = 1'b0;
    if (state_d == ISSUE) m_read_d = (credits_d < CRD_W'(FIFO_DEPTH));
    if (start_ok && (word_count == 16'd0)) done_d = 1'b1;
    if ((state_q == DRAIN) && last_pop) done_d = 1'b1;
  end

  // Output registers, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_read_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      pending_q   <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      m_read_q <= m_read_d;
      busy     <= busy_d;
      done     <= done_d;
      if (start_ok) begin
        count_q     <= word_count;
        issued_q    <= '0;
        delivered_q <= '0;
        addr_q      <= base_addr & ~ADDR_W'(3);
      end else begin
        if (accept) begin
          issued_q <= issued_q + 16'd1;
          addr_q   <= addr_q + ADDR_W'(4);
        end
        if (pop) delivered_q <= delivered_q + 16'd1;
      end
      pending_q  <= pending_q + CNT_W'(accept) - CNT_W'(push);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.m_readdata;
  end

  assign bus.m_address = addr_q;
  assign bus.m_read    = m_read_q;
  assign bus.out_valid = (fifo_cnt_q != '0);
  assign bus.out_data  = fifo_mem[rd_ptr_q];
endmodule
